// File: rtl/branch_cond_pkg.sv
// Shared definitions for branch_cond_unit: condition code encodings and flag bit positions.
// Also lists the condition codes of the optional loop counter (LOOP_CNT_EN).
package branch_cond_pkg;

    localparam int unsigned COND_BITS = 5;

    // Register/register compares
    localparam logic [4:0] COND_GTU  = 5'b00000;
    localparam logic [4:0] COND_LTU  = 5'b00001;
    localparam logic [4:0] COND_EQ   = 5'b00010;
    localparam logic [4:0] COND_NE   = 5'b00011;
    localparam logic [4:0] COND_EQZ  = 5'b00100;
    localparam logic [4:0] COND_NEG  = 5'b00101;
    localparam logic [4:0] COND_GTS  = 5'b00110;
    localparam logic [4:0] COND_LTS  = 5'b00111;

    // Register/immediate compares
    localparam logic [4:0] COND_GTUI = 5'b01000;
    localparam logic [4:0] COND_LTUI = 5'b01001;
    localparam logic [4:0] COND_EQI  = 5'b01010;
    localparam logic [4:0] COND_NEI  = 5'b01011;
    localparam logic [4:0] COND_GTSI = 5'b01110;
    localparam logic [4:0] COND_LTSI = 5'b01111;

    // Flags register: compare now, branch later
    localparam logic [4:0] COND_CMPF = 5'b10000;
    localparam logic [4:0] COND_JZF  = 5'b10001;
    localparam logic [4:0] COND_JNF  = 5'b10010;
    localparam logic [4:0] COND_JCF  = 5'b10011;
    localparam logic [4:0] COND_JVF  = 5'b10100;

    // Hardware loop counter and unconditional jump
    localparam logic [4:0] COND_LDC  = 5'b11000;
    localparam logic [4:0] COND_DJNZ = 5'b11001;
    localparam logic [4:0] COND_JMP  = 5'b11111;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational condition evaluation: jump decision for every code except DJNZ,
// plus the {V,C,N,Z} value a CMPF would write (rd - rs, WIDTH+1 bits).
module cond_eval
    import branch_cond_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       cond,
    input  logic [WIDTH-1:0] rd,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] imm,
    input  logic [3:0]       flags,
    output logic             jump,
    output logic [3:0]       cmp_flags
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff = {1'b0, rd} - {1'b0, rs};
        cmp_flags         = 4'b0000;
        cmp_flags[FLAG_Z] = (diff[WIDTH-1:0] == '0);
        cmp_flags[FLAG_N] = diff[WIDTH-1];
        cmp_flags[FLAG_C] = diff[WIDTH];
        // Overflow only when operand signs differ and the result sign leaves rd's
        cmp_flags[FLAG_V] = (rd[WIDTH-1] != rs[WIDTH-1]) && (diff[WIDTH-1] != rd[WIDTH-1]);
    end

    always_comb begin
        jump = 1'b0;
        case (cond)
            COND_GTU:  jump = rd > rs;
            COND_LTU:  jump = rd < rs;
            COND_EQ:   jump = rd == rs;
            COND_NE:   jump = rd != rs;
            COND_EQZ:  jump = rd == '0;
            COND_NEG:  jump = rd[WIDTH-1];
            COND_GTS:  jump = $signed(rd) > $signed(rs);
            COND_LTS:  jump = $signed(rd) < $signed(rs);
            COND_GTUI: jump = rd > imm;
            COND_LTUI: jump = rd < imm;
            COND_EQI:  jump = rd == imm;
            COND_NEI:  jump = rd != imm;
            COND_GTSI: jump = $signed(rd) > $signed(imm);
            COND_LTSI: jump = $signed(rd) < $signed(imm);
            COND_JZF:  jump = flags[FLAG_Z];
            COND_JNF:  jump = flags[FLAG_N];
            COND_JCF:  jump = flags[FLAG_C];
            COND_JVF:  jump = flags[FLAG_V];
            COND_JMP:  jump = 1'b1;
            default:   jump = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch decision unit with flags register and hardware loop counter.
// Define LOOP_CNT_EN to build the loop counter (LDC / DJNZ); otherwise loop_cnt is tied to 0.
module branch_cond_unit
    import branch_cond_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int COND_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COND_W-1:0] cond,
    input  logic [WIDTH-1:0]  rd_data,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              jump,
    output logic [3:0]        flags,
    output logic [WIDTH-1:0]  loop_cnt
);

    logic       accept;
    logic       eval_jump;
    logic       next_jump;
    logic [3:0] cmp_flags;

    // Handshake: a request is accepted when in_valid && in_ready; in_ready is high
    // whenever the output slot is empty or is being retired this cycle, so a held
    // result stays stable until out_ready and back-to-back requests flow 1/cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .cond      (cond[COND_BITS-1:0]),
        .rd        (rd_data),
        .rs        (rs_data),
        .imm       (imm),
        .flags     (flags),
        .jump      (eval_jump),
        .cmp_flags (cmp_flags)
    );

`ifdef LOOP_CNT_EN
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_dec;

    assign cnt_dec   = cnt_q - WIDTH'(1);
    // DJNZ branches only if the decremented count is still non-zero; 0 never wraps
    assign next_jump = (cond == COND_DJNZ) ? ((cnt_q != '0) && (cnt_dec != '0)) : eval_jump;
    assign loop_cnt  = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            if (cond == COND_LDC) begin
                cnt_q <= rd_data;
            end else if ((cond == COND_DJNZ) && (cnt_q != '0)) begin
                cnt_q <= cnt_dec;
            end
        end
    end
`else
    assign next_jump = eval_jump;
    assign loop_cnt  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            jump      <= 1'b0;
            flags     <= 4'b0000;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                jump      <= next_jump;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && (cond == COND_CMPF)) begin
                flags <= cmp_flags;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed-vector bench for branch_cond_unit; the loop counter scenario follows LOOP_CNT_EN.
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  cond;
    logic [15:0] rd_data;
    logic [15:0] rs_data;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic        jump;
    logic [3:0]  flags;
    logic [15:0] loop_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [4:0]  c;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] n;
        logic        j;
    } vec_t;

    vec_t cmp_tab [0:17];

    branch_cond_unit #(.WIDTH(16), .COND_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cond      (cond),
        .rd_data   (rd_data),
        .rs_data   (rs_data),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .jump      (jump),
        .flags     (flags),
        .loop_cnt  (loop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Drive one request starting at a negedge; the result is visible at the following negedge.
    task automatic do_op(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] n);
        cond     = c;
        rd_data  = a;
        rs_data  = b;
        imm      = n;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cond      = 5'b0;
        rd_data   = 16'h0;
        rs_data   = 16'h0;
        imm       = 16'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vec_cnt++;
        if (jump !== 1'b0) begin err_cnt++; $display("FAIL reset_jump got %b want 0", jump); end
        vec_cnt++;
        if (flags !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags got %b want 0000", flags); end
        vec_cnt++;
        if (loop_cnt !== 16'h0) begin err_cnt++; $display("FAIL reset_loop_cnt got %h want 0000", loop_cnt); end
        vec_cnt++;
        if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_compare;
        cmp_tab = '{
            '{5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1},
            '{5'b00110, 16'hFFFF, 16'h0001, 16'h0000, 1'b0},
            '{5'b00001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0},
            '{5'b00111, 16'hFFFF, 16'h0001, 16'h0000, 1'b1},
            '{5'b00010, 16'h1234, 16'h1234, 16'h0000, 1'b1},
            '{5'b00011, 16'h1234, 16'h1234, 16'h0000, 1'b0},
            '{5'b00100, 16'h0000, 16'h5555, 16'h0000, 1'b1},
            '{5'b00101, 16'h8000, 16'h0000, 16'h0000, 1'b1},
            '{5'b01000, 16'h0005, 16'h0000, 16'h0003, 1'b1},
            '{5'b01001, 16'h0005, 16'h0000, 16'h0003, 1'b0},
            '{5'b01010, 16'h0003, 16'h0009, 16'h0003, 1'b1},
            '{5'b01011, 16'h0003, 16'h0009, 16'h0003, 1'b0},
            '{5'b01110, 16'hFFFE, 16'h0000, 16'h0002, 1'b0},
            '{5'b01111, 16'hFFFE, 16'h0000, 16'h0002, 1'b1},
            '{5'b11111, 16'h0000, 16'h0000, 16'h0000, 1'b1},
            '{5'b01100, 16'h0005, 16'h0001, 16'h0000, 1'b0},
            '{5'b10101, 16'h0005, 16'h0001, 16'h0000, 1'b0},
            '{5'b00000, 16'h0001, 16'h0001, 16'h0000, 1'b0}
        };
        for (int i = 0; i < 18; i++) begin
            do_op(cmp_tab[i].c, cmp_tab[i].a, cmp_tab[i].b, cmp_tab[i].n);
            vec_cnt++;
            if (out_valid !== 1'b1 || jump !== cmp_tab[i].j) begin
                err_cnt++;
                $display("FAIL compare[%0d] cond=%b got valid=%b jump=%b want valid=1 jump=%b",
                         i, cmp_tab[i].c, out_valid, jump, cmp_tab[i].j);
            end
        end
        vec_cnt++;
        if (flags !== 4'b0000) begin err_cnt++; $display("FAIL compare_flags_untouched got %b want 0000", flags); end
    endtask

    task automatic test_flags;
        do_op(5'b10000, 16'h8000, 16'h0001, 16'h0);
        vec_cnt++;
        if (jump !== 1'b0 || flags !== 4'b1000) begin
            err_cnt++; $display("FAIL cmpf_ovf got jump=%b flags=%b want jump=0 flags=1000", jump, flags);
        end
        do_op(5'b10100, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b1) begin err_cnt++; $display("FAIL jvf_after_ovf got %b want 1", jump); end
        do_op(5'b10001, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b0) begin err_cnt++; $display("FAIL jzf_after_ovf got %b want 0", jump); end
        do_op(5'b10011, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b0) begin err_cnt++; $display("FAIL jcf_after_ovf got %b want 0", jump); end
        do_op(5'b10000, 16'h0005, 16'h0005, 16'h0);
        vec_cnt++;
        if (flags !== 4'b0001) begin err_cnt++; $display("FAIL cmpf_equal got %b want 0001", flags); end
        do_op(5'b10001, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b1) begin err_cnt++; $display("FAIL jzf_after_equal got %b want 1", jump); end
        do_op(5'b10000, 16'h0000, 16'h8000, 16'h0);
        vec_cnt++;
        if (flags !== 4'b1110) begin err_cnt++; $display("FAIL cmpf_borrow got %b want 1110", flags); end
        do_op(5'b10010, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b1) begin err_cnt++; $display("FAIL jnf_after_borrow got %b want 1", jump); end
        do_op(5'b10011, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b1) begin err_cnt++; $display("FAIL jcf_after_borrow got %b want 1", jump); end
        do_op(5'b11111, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (flags !== 4'b1110) begin err_cnt++; $display("FAIL flags_hold got %b want 1110", flags); end
    endtask

    task automatic test_loop;
        logic [15:0] exp_cnt [0:3];
        logic        exp_j   [0:3];
`ifdef LOOP_CNT_EN
        exp_cnt = '{16'd2, 16'd1, 16'd0, 16'd0};
        exp_j   = '{1'b1, 1'b1, 1'b0, 1'b0};
        do_op(5'b11000, 16'd3, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b0 || loop_cnt !== 16'd3) begin
            err_cnt++; $display("FAIL ldc got jump=%b cnt=%0d want jump=0 cnt=3", jump, loop_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            do_op(5'b11001, 16'h0, 16'h0, 16'h0);
            vec_cnt++;
            if (jump !== exp_j[i] || loop_cnt !== exp_cnt[i]) begin
                err_cnt++;
                $display("FAIL djnz[%0d] got jump=%b cnt=%0d want jump=%b cnt=%0d",
                         i, jump, loop_cnt, exp_j[i], exp_cnt[i]);
            end
        end
`else
        exp_cnt = '{16'd0, 16'd0, 16'd0, 16'd0};
        exp_j   = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_op(5'b11000, 16'd7, 16'h0, 16'h0);
        vec_cnt++;
        if (jump !== 1'b0 || loop_cnt !== 16'd0) begin
            err_cnt++; $display("FAIL ldc_disabled got jump=%b cnt=%0d want jump=0 cnt=0", jump, loop_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            do_op(5'b11001, 16'h0, 16'h0, 16'h0);
            vec_cnt++;
            if (jump !== exp_j[i] || loop_cnt !== exp_cnt[i]) begin
                err_cnt++;
                $display("FAIL djnz_disabled[%0d] got jump=%b cnt=%0d want jump=0 cnt=0", i, jump, loop_cnt);
            end
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [4:0] c_seq [0:4];
        logic       j_seq [0:4];
        c_seq = '{5'b10000, 5'b10001, 5'b10000, 5'b10001, 5'b10010};
        j_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cond    = c_seq[i];
            rd_data = (i < 2) ? 16'h0005 : 16'h0001;
            rs_data = (i < 2) ? 16'h0005 : 16'h0002;
            imm     = 16'h0;
            @(negedge clk);
            vec_cnt++;
            if (out_valid !== 1'b1 || jump !== j_seq[i]) begin
                err_cnt++;
                $display("FAIL b2b[%0d] got valid=%b jump=%b want valid=1 jump=%b", i, out_valid, jump, j_seq[i]);
            end
        end
`ifdef LOOP_CNT_EN
        cond = 5'b11000; rd_data = 16'd2;
        @(negedge clk);
        cond = 5'b11001;
        @(negedge clk);
        vec_cnt++;
        if (jump !== 1'b1 || loop_cnt !== 16'd1) begin
            err_cnt++; $display("FAIL b2b_ldc_djnz got jump=%b cnt=%0d want jump=1 cnt=1", jump, loop_cnt);
        end
`endif
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit dropped;
        out_ready = 1'b0;
        do_op(5'b11111, 16'h0, 16'h0, 16'h0);
        cond = 5'b00100; rd_data = 16'h0005; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || jump !== 1'b1) begin
                err_cnt++;
                $display("FAIL stall[%0d] got ready=%b valid=%b jump=%b want ready=0 valid=1 jump=1",
                         i, in_ready, out_valid, jump);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL retire_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b1 || jump !== 1'b0) begin
            err_cnt++; $display("FAIL retire_accept got valid=%b jump=%b want valid=1 jump=0", out_valid, jump);
        end
        dropped = 1'b0;
        for (int i = 0; i < 5 && !dropped; i++) begin
            @(negedge clk);
            if (out_valid === 1'b0) dropped = 1'b1;
        end
        vec_cnt++;
        if (!dropped) begin err_cnt++; $display("FAIL drain got valid=%b want 0 within 5 cycles", out_valid); end
    endtask

    task automatic test_reset_mid;
        do_op(5'b10000, 16'h0000, 16'h8000, 16'h0);
`ifdef LOOP_CNT_EN
        do_op(5'b11000, 16'd5, 16'h0, 16'h0);
        vec_cnt++;
        if (loop_cnt !== 16'd5) begin err_cnt++; $display("FAIL pre_reset_cnt got %0d want 5", loop_cnt); end
`endif
        out_ready = 1'b0;
        do_op(5'b11111, 16'h0, 16'h0, 16'h0);
        vec_cnt++;
        if (out_valid !== 1'b1 || flags !== 4'b1110) begin
            err_cnt++; $display("FAIL pre_reset got valid=%b flags=%b want valid=1 flags=1110", out_valid, flags);
        end
        reset = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (out_valid !== 1'b0 || jump !== 1'b0 || flags !== 4'b0000 || loop_cnt !== 16'h0 || in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL mid_reset got valid=%b jump=%b flags=%b cnt=%h ready=%b want 0 0 0000 0000 1",
                     out_valid, jump, flags, loop_cnt, in_ready);
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_compare();
        test_flags();
        test_loop();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
